// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage.
// Opcodes, boolean constants, fetch FSM states and immediate extraction.
package inst_fetcher_pkg;

    localparam logic [6:0] JALOP   = 7'b1101111;
    localparam logic [6:0] JALROP  = 7'b1100111;
    localparam logic [6:0] BROP    = 7'b1100011;
    localparam logic [6:0] AUIPCOP = 7'b0010111;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        JSTALL,
        DISCARD
    } if_state_t;

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// Branch history table of 2-bit saturating counters.
// One combinational lookup port, one committed-outcome update port.
module branch_predictor
    import inst_fetcher_pkg::*;
#(
    parameter int BHT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [BHT_BITS-1:0] lookup_idx,
    output logic                lookup_taken,
    input  logic                upd_sgn,
    input  logic [BHT_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int N = 1 << BHT_BITS;

    logic [1:0] bht [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) bht[i] <= 2'b01;
        end else if (rdy && upd_sgn) begin
            if (upd_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            else if (!upd_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
        end
    end

    // Read sees the pre-update value on a same-cycle index collision.
    assign lookup_taken = bht[lookup_idx][1];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC walk, icache request, JAL/branch prediction.
// Define BHT_EN to enable the 2-bit branch history table.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ICACHE_sgn,
    output logic [31:0] ICACHE_addr,
    input  logic        ICACHE_ins_sgn,
    input  logic [31:0] ICACHE_ins,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        IF_jump_flag,
    output logic [31:0] IF_jump_pc,
    input  logic        ROB_full,
    input  logic        LSB_full,
    input  logic        ROB_clr,
    input  logic [31:0] ROB_clr_pc,
    input  logic        ROB_br_sgn,
    input  logic [31:0] ROB_br_pc,
    input  logic        ROB_br_taken
);

    if_state_t   state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_n, vld_n, flag_n;
    logic [31:0] addr_n, ins_n, jpc_n;
    logic [31:0] pred_pc, pred_jpc;
    logic        pred_flag, br_taken, consume;
    logic        unused_br;

`ifdef BHT_EN
    branch_predictor #(.BHT_BITS(BHT_BITS)) u_bp (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .lookup_idx   (pc[BHT_BITS+1:2]),
        .lookup_taken (br_taken),
        .upd_sgn      (ROB_br_sgn),
        .upd_idx      (ROB_br_pc[BHT_BITS+1:2]),
        .upd_taken    (ROB_br_taken)
    );
    assign unused_br = ^{ROB_br_pc[31:BHT_BITS+2], ROB_br_pc[1:0]};
`else
    assign br_taken  = False;
    assign unused_br = ^{ROB_br_sgn, ROB_br_pc, ROB_br_taken};
`endif

    assign consume = IF_ins_sgn && !ROB_full && !LSB_full && rdy;

    always_comb begin
        pred_pc   = pc + 32'd4;
        pred_jpc  = pc + 32'd4;
        pred_flag = False;
        unique case (ICACHE_ins[6:0])
            JALOP: begin
                pred_pc   = pc + imm_j(ICACHE_ins);
                pred_flag = True;
            end
            BROP: begin
                if (br_taken) begin
                    pred_pc   = pc + imm_b(ICACHE_ins);
                    pred_flag = True;
                end else begin
                    pred_jpc  = pc + imm_b(ICACHE_ins);
                end
            end
            AUIPCOP: pred_jpc = pc;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = ICACHE_sgn;
        addr_n  = ICACHE_addr;
        vld_n   = IF_ins_sgn;
        ins_n   = IF_ins;
        flag_n  = IF_jump_flag;
        jpc_n   = IF_jump_pc;
        if (rdy) begin
            if (ROB_clr) begin
                pc_n  = ROB_clr_pc;
                vld_n = False;
                if ((state == FETCH && !ICACHE_ins_sgn) || state == DISCARD) begin
                    state_n = DISCARD;
                    req_n   = False;
                end else begin
                    state_n = FETCH;
                    req_n   = True;
                    addr_n  = ROB_clr_pc;
                end
            end else begin
                unique case (state)
                    FETCH: if (ICACHE_ins_sgn) begin
                        ins_n   = ICACHE_ins;
                        vld_n   = True;
                        flag_n  = pred_flag;
                        jpc_n   = pred_jpc;
                        pc_n    = pred_pc;
                        req_n   = False;
                        state_n = HOLD;
                    end
                    HOLD: if (consume) begin
                        vld_n = False;
                        if (IF_ins[6:0] == JALROP) begin
                            state_n = JSTALL;
                        end else begin
                            state_n = FETCH;
                            req_n   = True;
                            addr_n  = pc;
                        end
                    end
                    DISCARD: if (ICACHE_ins_sgn) begin
                        state_n = FETCH;
                        req_n   = True;
                        addr_n  = pc;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            ICACHE_sgn   <= True;
            ICACHE_addr  <= RESET_PC;
            IF_ins_sgn   <= False;
            IF_ins       <= '0;
            IF_jump_flag <= False;
            IF_jump_pc   <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            ICACHE_sgn   <= req_n;
            ICACHE_addr  <= addr_n;
            IF_ins_sgn   <= vld_n;
            IF_ins       <= ins_n;
            IF_jump_flag <= flag_n;
            IF_jump_pc   <= jpc_n;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed testbench for inst_fetcher with hand-computed expectations.
// Expectations follow BHT_EN when the macro is defined.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ICACHE_sgn;
    logic [31:0] ICACHE_addr;
    logic        ICACHE_ins_sgn;
    logic [31:0] ICACHE_ins;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        IF_jump_flag;
    logic [31:0] IF_jump_pc;
    logic        ROB_full, LSB_full, ROB_clr;
    logic [31:0] ROB_clr_pc;
    logic        ROB_br_sgn;
    logic [31:0] ROB_br_pc;
    logic        ROB_br_taken;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] JAL   = 32'h0200_006F;
    localparam logic [31:0] BEQ   = 32'hFE00_0CE3;
    localparam logic [31:0] JALR  = 32'h0000_8067;
    localparam logic [31:0] AUIPC = 32'h0000_0097;

`ifdef BHT_EN
    localparam logic        BR_FLAG = 1'b1;
    localparam logic [31:0] BR_JPC  = 32'h44;
    localparam logic [31:0] BR_NEXT = 32'h38;
`else
    localparam logic        BR_FLAG = 1'b0;
    localparam logic [31:0] BR_JPC  = 32'h38;
    localparam logic [31:0] BR_NEXT = 32'h44;
`endif

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ICACHE_sgn     (ICACHE_sgn),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_ins_sgn (ICACHE_ins_sgn),
        .ICACHE_ins     (ICACHE_ins),
        .IF_ins_sgn     (IF_ins_sgn),
        .IF_ins         (IF_ins),
        .IF_jump_flag   (IF_jump_flag),
        .IF_jump_pc     (IF_jump_pc),
        .ROB_full       (ROB_full),
        .LSB_full       (LSB_full),
        .ROB_clr        (ROB_clr),
        .ROB_clr_pc     (ROB_clr_pc),
        .ROB_br_sgn     (ROB_br_sgn),
        .ROB_br_pc      (ROB_br_pc),
        .ROB_br_taken   (ROB_br_taken)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic resp(input logic [31:0] w);
        ICACHE_ins_sgn = 1'b1;
        ICACHE_ins     = w;
        @(negedge clk);
        ICACHE_ins_sgn = 1'b0;
        ICACHE_ins     = '0;
    endtask

    task automatic consume();
        ROB_full = 1'b0;
        @(negedge clk);
        ROB_full = 1'b1;
    endtask

    task automatic clr(input logic [31:0] p);
        ROB_clr    = 1'b1;
        ROB_clr_pc = p;
        @(negedge clk);
        ROB_clr    = 1'b0;
    endtask

    task automatic br_upd(input logic [31:0] p, input logic t);
        ROB_br_sgn   = 1'b1;
        ROB_br_pc    = p;
        ROB_br_taken = t;
        @(negedge clk);
        ROB_br_sgn   = 1'b0;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] a);
        check({tag, "_req"}, {31'd0, ICACHE_sgn}, 32'd1);
        check({tag, "_addr"}, ICACHE_addr, a);
        check({tag, "_vld"}, {31'd0, IF_ins_sgn}, 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ins,
                           input logic fl, input logic [31:0] jpc);
        check({tag, "_vld"}, {31'd0, IF_ins_sgn}, 32'd1);
        check({tag, "_ins"}, IF_ins, ins);
        check({tag, "_flag"}, {31'd0, IF_jump_flag}, {31'd0, fl});
        check({tag, "_jpc"}, IF_jump_pc, jpc);
        check({tag, "_req"}, {31'd0, ICACHE_sgn}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        ICACHE_ins_sgn = 1'b0; ICACHE_ins = '0;
        ROB_full = 1'b1; LSB_full = 1'b0;
        ROB_clr = 1'b0; ROB_clr_pc = '0;
        ROB_br_sgn = 1'b0; ROB_br_pc = '0; ROB_br_taken = 1'b0;
        repeat (2) @(negedge clk);
        chk_fetch("rst", 32'h0);
        check("rst_ins", IF_ins, 32'h0);
        check("rst_flag", {31'd0, IF_jump_flag}, 32'd0);
        check("rst_jpc", IF_jump_pc, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk_fetch("req0", 32'h0);

        resp(ADDI);
        chk_out("addi", ADDI, 1'b0, 32'h4);
        consume();
        chk_fetch("next4", 32'h4);

        @(negedge clk);
        clr(32'h200);
        check("disc_req", {31'd0, ICACHE_sgn}, 32'd0);
        check("disc_vld", {31'd0, IF_ins_sgn}, 32'd0);
        @(negedge clk);
        resp(ADDI);
        chk_fetch("after_disc", 32'h200);

        ROB_clr = 1'b1; ROB_clr_pc = 32'h10;
        resp(ADDI);
        ROB_clr = 1'b0;
        chk_fetch("clr_resp", 32'h10);

        resp(JAL);
        chk_out("jal", JAL, 1'b1, 32'h14);
        consume();
        chk_fetch("jal_next", 32'h30);

        resp(ADDI);
        chk_out("addi30", ADDI, 1'b0, 32'h34);
        clr(32'h40);
        chk_fetch("hold_clr", 32'h40);

        resp(BEQ);
        chk_out("beq_nt", BEQ, 1'b0, 32'h38);
        consume();
        chk_fetch("beq_next", 32'h44);

        br_upd(32'h40, 1'b1);
        br_upd(32'h40, 1'b1);
        rdy = 1'b0;
        resp(ADDI);
        rdy = 1'b1;
        chk_fetch("rdy_frz", 32'h44);

        resp(ADDI);
        chk_out("addi44", ADDI, 1'b0, 32'h48);
        clr(32'h40);
        resp(BEQ);
        chk_out("beq_tr", BEQ, BR_FLAG, BR_JPC);
        consume();
        chk_fetch("beq_tr_next", BR_NEXT);

        resp(JALR);
        chk_out("jalr", JALR, 1'b0, BR_NEXT + 32'd4);
        for (int i = 0; i < 3; i++) begin
            ROB_full = (i == 0);
            LSB_full = (i == 1);
            rdy      = (i != 2);
            @(negedge clk);
            check("jalr_hold_vld", {31'd0, IF_ins_sgn}, 32'd1);
            check("jalr_hold_ins", IF_ins, JALR);
        end
        ROB_full = 1'b1; LSB_full = 1'b0; rdy = 1'b1;
        consume();
        check("jalr_cons_vld", {31'd0, IF_ins_sgn}, 32'd0);
        repeat (3) @(negedge clk);
        check("jstall_req", {31'd0, ICACHE_sgn}, 32'd0);
        clr(32'h100);
        chk_fetch("jstall_clr", 32'h100);

        resp(AUIPC);
        chk_out("auipc", AUIPC, 1'b0, 32'h100);
        consume();
        chk_fetch("auipc_next", 32'h104);

        rst = 1'b1;
        #2;
        chk_fetch("arst", 32'h0);
        check("arst_ins", IF_ins, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_fetch("post_rst", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
